spi_bus_arbiter: RTL and testbench

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

---
 rtl/spi_bus_arbiter_pkg.sv | 35 +++
 rtl/spi_bus_arbiter_rr_pick.sv | 28 ++
 rtl/spi_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bus_arbiter_pkg
//  Description : Shared types and constants for the SPI bus arbiter: FSM
//                state encoding, requester indices and timing defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_bus_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    // Requester indices into the per-requester buses
    localparam int DISP = 0;
    localparam int KBD  = 1;

    // Default chip-select timing, in i_Clk cycles
    localparam int CS_SETUP_CLKS_DEF = 2;
    localparam int CS_HOLD_CLKS_DEF  = 2;
    localparam int GAP_CLKS_DEF      = 1;

    // Bits needed to count 0 .. n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rr_pick
//  Description : Two-way combinational round-robin picker. On a tie the
//                requester that was not granted last time wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_pick
    import spi_bus_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,   // index of the requester granted last
    output logic [1:0] o_gnt
);

    // One-hot winner selection
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt[DISP] = 1'b1;
            2'b10:   o_gnt[KBD]  = 1'b1;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bus_arbiter
//  Description : Shares one SPI master between a display and a keyboard.
//                Grants whole bursts round-robin, frames each burst with
//                chip-select setup/hold/gap timing and forwards bytes to the
//                master with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int CS_SETUP_CLKS = CS_SETUP_CLKS_DEF,
    parameter int CS_HOLD_CLKS  = CS_HOLD_CLKS_DEF,
    parameter int GAP_CLKS      = GAP_CLKS_DEF
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [1:0]  i_Req,
    output logic [1:0]  o_Gnt,
    input  logic [15:0] i_TX_Byte,
    input  logic [1:0]  i_TX_DV,
    input  logic [1:0]  i_Last,
    input  logic [1:0]  i_DC,
    output logic [1:0]  o_TX_Ready,
    output logic [1:0]  o_RX_DV,
    output logic [7:0]  o_RX_Byte,
    output logic [7:0]  o_SPI_TX_Byte,
    output logic        o_SPI_TX_DV,
    input  logic        i_SPI_TX_Ready,
    input  logic        i_SPI_RX_DV,
    input  logic [7:0]  i_SPI_RX_Byte,
    output logic [1:0]  o_CS_n,
    output logic        o_DC
);

    // One shared counter wide enough for the longest timed state
    localparam int c_CNT_MAX = (CS_SETUP_CLKS > CS_HOLD_CLKS)
                             ? ((CS_SETUP_CLKS > GAP_CLKS) ? CS_SETUP_CLKS : GAP_CLKS)
                             : ((CS_HOLD_CLKS  > GAP_CLKS) ? CS_HOLD_CLKS  : GAP_CLKS);
    localparam int c_CNT_W   = cnt_width(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    spi_state_e           state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 last_gnt_q, last_gnt_d;   // 0 = display, 1 = keyboard
    logic                 pend_q, pend_d;           // byte handed over, master not yet busy
    logic                 tx_dv_q, tx_dv_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic                 dc_q, dc_d;

    logic [1:0]           w_pick;
    logic                 w_accept;
    logic                 w_last_g;
    logic                 w_dc_g;
    logic [7:0]           w_sel_byte;

    spi_rr_pick u_rr_pick (
        .i_req  (i_Req),
        .i_last (last_gnt_q),
        .o_gnt  (w_pick)
    );

    // Only the owner may push a byte, and only while the master is free
    assign o_TX_Ready = (state_q == ST_XFER && i_SPI_TX_Ready && !pend_q) ? gnt_q : 2'b00;
    assign w_accept   = |(i_TX_DV & o_TX_Ready);
    assign w_last_g   = |(i_Last & gnt_q);
    assign w_dc_g     = |(i_DC & gnt_q);
    assign w_sel_byte = gnt_q[KBD] ? i_TX_Byte[15:8] : i_TX_Byte[7:0];

    assign o_Gnt         = gnt_q;
    assign o_CS_n        = ~gnt_q;   // chip select is low exactly while granted
    assign o_RX_DV       = i_SPI_RX_DV ? gnt_q : 2'b00;
    assign o_RX_Byte     = i_SPI_RX_Byte;
    assign o_SPI_TX_Byte = tx_byte_q;
    assign o_SPI_TX_DV   = tx_dv_q;
    assign o_DC          = dc_q;

    // Next-state, byte capture and chip-select sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        pend_d     = pend_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        dc_d       = dc_q;

        // The master dropping ready means it has taken the pending byte
        if (w_accept) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = w_sel_byte;
            dc_d      = w_dc_g;
            pend_d    = 1'b1;
        end else if (!i_SPI_TX_Ready) begin
            pend_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (|i_Req) begin
                    gnt_d      = w_pick;
                    last_gnt_d = w_pick[KBD];
                    cnt_d      = '0;
                    state_d    = (CS_SETUP_CLKS == 0) ? ST_XFER : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == c_SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else begin
                    cnt_d   = cnt_q + c_CNT_ONE;
                end
            end
            ST_XFER: begin
                if (w_accept && w_last_g) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Last byte is done once the master went busy and came back
                if (!pend_q && i_SPI_TX_Ready) begin
                    cnt_d = '0;
                    if (CS_HOLD_CLKS != 0) begin
                        state_d = ST_HOLD;
                    end else begin
                        gnt_d   = 2'b00;
                        state_d = (GAP_CLKS != 0) ? ST_GAP : ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == c_HOLD_LAST) begin
                    cnt_d   = '0;
                    gnt_d   = 2'b00;
                    state_d = (GAP_CLKS != 0) ? ST_GAP : ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + c_CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any pending byte
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gnt_q      <= 2'b00;
            last_gnt_q <= 1'b1;      // keyboard "last" so display wins first
            pend_q     <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            dc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            pend_q     <= pend_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            dc_q       <= dc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_bus_arbiter
//  Description : Self-checking bench for spi_bus_arbiter with a timer-based
//                reference model, a simple SPI master agent, directed bursts
//                and a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int GAP   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, tx_dv, last, dc;
    logic [15:0] tx_byte;
    logic        spi_rdy, spi_rx_dv;
    logic [7:0]  spi_rx_byte;
    logic [1:0]  o_Gnt, o_TX_Ready, o_RX_DV, o_CS_n;
    logic [7:0]  o_RX_Byte, o_SPI_TX_Byte;
    logic        o_SPI_TX_DV, o_DC;

    always #5 clk = ~clk;

    spi_bus_arbiter dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Req          (req),
        .o_Gnt          (o_Gnt),
        .i_TX_Byte      (tx_byte),
        .i_TX_DV        (tx_dv),
        .i_Last         (last),
        .i_DC           (dc),
        .o_TX_Ready     (o_TX_Ready),
        .o_RX_DV        (o_RX_DV),
        .o_RX_Byte      (o_RX_Byte),
        .o_SPI_TX_Byte  (o_SPI_TX_Byte),
        .o_SPI_TX_DV    (o_SPI_TX_DV),
        .i_SPI_TX_Ready (spi_rdy),
        .i_SPI_RX_DV    (spi_rx_dv),
        .i_SPI_RX_Byte  (spi_rx_byte),
        .o_CS_n         (o_CS_n),
        .o_DC           (o_DC)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the bus and how long each phase has left
    int         m_owner;      // -1 none, else requester index
    int         m_next;       // tie winner for the next arbitration
    int         m_setup, m_hold, m_gap;
    bit         m_xfer, m_drain, m_pend, m_dv, m_dc;
    logic [7:0] m_byte;

    // Master agent state
    int         mst_busy;
    bit         last_dv;
    logic [7:0] mst_rx_byte;

    // Observations for directed checks
    logic [7:0] cap_q[$];
    int         rx0_hits, rx1_hits;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_next = 0;
        m_setup = 0; m_hold = 0; m_gap = 0;
        m_xfer = 0; m_drain = 0; m_pend = 0; m_dv = 0; m_dc = 0;
        m_byte = 8'h00;
    endtask

    task automatic master_reset();
        spi_rdy = 1'b1; spi_rx_dv = 1'b0; mst_busy = 0; last_dv = 1'b0;
    endtask

    function automatic logic [1:0] exp_gnt();
        return (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
    endfunction

    function automatic logic [1:0] exp_txrdy();
        return (m_xfer && spi_rdy && !m_pend) ? exp_gnt() : 2'b00;
    endfunction

    task automatic release_bus();
        m_owner = -1;
        m_gap   = GAP;
    endtask

    // Advance the model by one clock using the inputs of the ending cycle
    task automatic model_edge();
        bit acc, lst, old_pend;
        int g;
        if (!rst_n) return;
        g = m_owner;
        acc = 0; lst = 0;
        if (g >= 0) begin
            acc = m_xfer && spi_rdy && !m_pend && tx_dv[g];
            lst = acc && last[g];
        end
        old_pend = m_pend;
        m_dv = acc;
        if (acc) begin
            m_byte = (g == 1) ? tx_byte[15:8] : tx_byte[7:0];
            m_dc   = dc[g];
        end
        if (acc) m_pend = 1;
        else if (!spi_rdy) m_pend = 0;

        if (g < 0) begin
            if (m_gap > 0) m_gap--;
            else if (req != 2'b00) begin
                if (req == 2'b11) g = m_next;
                else g = req[1] ? 1 : 0;
                m_owner = g;
                m_next  = 1 - g;
                m_setup = SETUP;
                m_xfer  = (SETUP == 0);
            end
        end else if (m_setup > 0) begin
            m_setup--;
            if (m_setup == 0) m_xfer = 1;
        end else if (m_xfer) begin
            if (lst) begin m_xfer = 0; m_drain = 1; end
        end else if (m_drain) begin
            if (!old_pend && spi_rdy) begin
                m_drain = 0;
                m_hold  = HOLD;
                if (HOLD == 0) release_bus();
            end
        end else begin
            m_hold--;
            if (m_hold == 0) release_bus();
        end
    endtask

    // Master: busy for 1..3 cycles after each byte, RX pulse when it finishes
    task automatic master_edge();
        spi_rx_dv = 1'b0;
        if (!rst_n) return;
        if (last_dv) begin
            mst_busy = $urandom_range(1, 3);
            spi_rdy  = 1'b0;
        end else if (mst_busy > 0) begin
            mst_busy--;
            if (mst_busy == 0) begin
                spi_rdy   = 1'b1;
                spi_rx_dv = 1'b1;
            end
        end
        if (!spi_rx_dv && $urandom_range(0, 7) == 0) spi_rx_dv = 1'b1;
        spi_rx_byte = mst_rx_byte;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        master_edge();
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic check();
        logic [1:0] eg;
        #1;
        eg = exp_gnt();
        cmp("cycle",
            {6'd0, o_Gnt, o_CS_n, o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_TX_Byte, o_SPI_TX_DV, o_DC},
            {6'd0, eg, ~eg, exp_txrdy(), (spi_rx_dv ? eg : 2'b00), spi_rx_byte, m_byte, m_dv, m_dc});
        cmp("cs_both_low", {31'd0, o_CS_n == 2'b00}, 32'd0);
        last_dv = o_SPI_TX_DV;
        if (o_SPI_TX_DV) cap_q.push_back(o_SPI_TX_Byte);
        if (o_RX_DV[0]) rx0_hits++;
        if (o_RX_DV[1] && o_RX_Byte == 8'h41) rx1_hits++;
    endtask

    // Drive one burst for requester 'who' until the bus is released
    task automatic burst(input int who, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n, input bit dcv,
                         output int granted, output int hold_cnt, output int idle_cs);
        logic [7:0] bytes [3];
        int  idx, cyc;
        bit  sent_last, saw_low, back;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        idx = 0; cyc = 0; granted = -1; hold_cnt = 0; idle_cs = 0;
        sent_last = 0; saw_low = 0; back = 0;
        while (cyc < 300) begin
            step();
            tx_dv = 2'b00; last = 2'b00;
            tx_byte = {$urandom_range(0, 255), $urandom_range(0, 255)} & 16'hFFFF;
            if (m_owner >= 0 && granted < 0) granted = m_owner;
            if (back && o_CS_n[who] == 1'b0) hold_cnt++;
            if (sent_last && !back) begin
                if (!spi_rdy) saw_low = 1;
                else if (saw_low) back = 1;
            end
            if (m_owner == who && idx < n && exp_txrdy()[who]) begin
                tx_dv[who] = 1'b1;
                if (who == 1) tx_byte[15:8] = bytes[idx]; else tx_byte[7:0] = bytes[idx];
                last[who] = (idx == n - 1);
                dc[who]   = dcv;
                if (idx == n - 1) sent_last = 1;
                idx++;
            end
            if ($urandom_range(0, 1) == 1) tx_dv[1 - who] = 1'b1;   // intruder
            check();
            if (granted >= 0 && o_CS_n == 2'b11) idle_cs++;
            cyc++;
            if (granted >= 0 && m_owner < 0) break;
        end
        if (cyc >= 300) cmp("burst_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int g0, g1, g2, g3, h, ic, dv_after;
        rst_n = 1'b0; req = 2'b00; tx_dv = 2'b00; last = 2'b00; dc = 2'b00;
        tx_byte = 16'h0000; mst_rx_byte = 8'h00; spi_rx_byte = 8'h00;
        rx0_hits = 0; rx1_hits = 0;
        model_reset(); master_reset();

        // Reset state
        repeat (2) begin step(); check(); end
        cmp("reset_gnt",   {30'd0, o_Gnt}, 32'h0);
        cmp("reset_cs",    {30'd0, o_CS_n}, 32'h3);
        cmp("reset_txrdy", {30'd0, o_TX_Ready}, 32'h0);
        cmp("reset_txdv",  {31'd0, o_SPI_TX_DV}, 32'h0);
        cmp("reset_dc",    {31'd0, o_DC}, 32'h0);
        cmp("reset_byte",  {24'd0, o_SPI_TX_Byte}, 32'h0);

        // First arbitration with both requesting goes to the display
        step(); rst_n = 1'b1; req = 2'b11; check();
        step(); check();
        cmp("first_gnt", {30'd0, o_Gnt}, 32'h1);
        cmp("first_cs",  {30'd0, o_CS_n}, 32'h2);
        step(); check();
        step(); check();
        cmp("setup_txrdy", {31'd0, o_TX_Ready[0]}, 32'h1);

        // Display burst with keyboard intruding, then alternation
        cap_q.delete();
        burst(0, 8'hAE, 8'hD5, 8'h80, 3, 1'b0, g0, h, ic);
        cmp("disp_nbytes", cap_q.size(), 32'd3);
        if (cap_q.size() == 3) begin
            cmp("disp_b0", {24'd0, cap_q[0]}, 32'hAE);
            cmp("disp_b1", {24'd0, cap_q[1]}, 32'hD5);
            cmp("disp_b2", {24'd0, cap_q[2]}, 32'h80);
        end
        cmp("disp_hold", h, 32'd2);
        cmp("disp_dc", {31'd0, o_DC}, 32'h0);
        cmp("gap_cs_high", {31'd0, ic >= 1}, 32'h1);

        mst_rx_byte = 8'h41; rx0_hits = 0; rx1_hits = 0;
        burst(1, 8'h11, 8'h22, 8'h00, 2, 1'b1, g1, h, ic);
        cmp("kbd_rx1", {31'd0, rx1_hits > 0}, 32'h1);
        cmp("kbd_rx0", rx0_hits, 32'd0);
        cmp("kbd_dc", {31'd0, o_DC}, 32'h1);
        cmp("kbd_hold", h, 32'd2);
        mst_rx_byte = 8'h00;

        burst(0, 8'h5A, 8'h00, 8'h00, 1, 1'b0, g2, h, ic);
        burst(1, 8'hC3, 8'h3C, 8'h99, 3, 1'b0, g3, h, ic);
        cmp("grant_seq", {g0[7:0], g1[7:0], g2[7:0], g3[7:0]}, 32'h00010001);

        // Reset during XFER with a byte just accepted
        req = 2'b01; tx_dv = 2'b00;
        for (int i = 0; i < 50; i++) begin
            step(); tx_dv = 2'b00; last = 2'b00;
            if (exp_txrdy()[0]) begin
                tx_dv = 2'b01; tx_byte = 16'h0055; check(); break;
            end
            check();
        end
        step();
        rst_n = 1'b0;
        #1;
        cmp("rst_gnt",  {30'd0, o_Gnt}, 32'h0);
        cmp("rst_cs",   {30'd0, o_CS_n}, 32'h3);
        cmp("rst_txdv", {31'd0, o_SPI_TX_DV}, 32'h0);
        model_reset(); master_reset();
        req = 2'b00; tx_dv = 2'b00; last = 2'b00;
        check();
        repeat (3) begin step(); check(); end
        step(); rst_n = 1'b1; check();
        dv_after = 0;
        repeat (6) begin step(); check(); if (o_SPI_TX_DV) dv_after++; end
        cmp("no_dv_after_rst", dv_after, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 1500) begin
                rst_n = 1'b0; model_reset(); master_reset(); check();
                step(); check();
                step(); rst_n = 1'b1;
            end
            req     = 2'($urandom_range(0, 3));
            tx_dv   = 2'($urandom_range(0, 3));
            last    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            dc      = 2'($urandom_range(0, 3));
            tx_byte = 16'($urandom());
            mst_rx_byte = 8'($urandom());
            check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
